// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: bus widths, ALU op codes, stall
// polarity, FSM state encoding and small op-decoding helpers.
package mem_access_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load_op(input logic [AluOpBus-1:0] op);
    logic r;
    case (op)
      EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store_op(input logic [AluOpBus-1:0] op);
    logic r;
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [AluOpBus-1:0] op,
                                         input logic [1:0]          lo);
    logic r;
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: r = lo[0];
      EXE_LW_OP, EXE_SW_OP:             r = (lo != 2'b00);
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  // Loads always fetch the whole word; stores enable only the lanes written.
  function automatic logic [3:0] bus_lanes(input logic [AluOpBus-1:0] op,
                                           input logic [1:0]          lo);
    logic [3:0] r;
    case (op)
      EXE_SB_OP: r = 4'b0001 << lo;
      EXE_SH_OP: r = lo[1] ? 4'b1100 : 4'b0011;
      default:   r = 4'b1111;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus interface between the MEM stage (master) and the memory
// responder (slave).
//   bus_req_o   request held until acknowledged
//   bus_we_o    1 = write
//   bus_sel_o   byte-lane enables
//   bus_addr_o  word-aligned address
//   bus_wdata_o lane-replicated store data
//   bus_ack_i   completion, may arrive in the request cycle
//   bus_rdata_i read word
interface mem_access_if;
  import mem_access_pkg::*;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [3:0]        bus_sel_o;
  logic [RegBus-1:0] bus_addr_o;
  logic [RegBus-1:0] bus_wdata_o;
  logic              bus_ack_i;
  logic [RegBus-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_access_load_extend.sv
// Combinational load formatter: picks the byte/halfword lane addressed by
// the low address bits and sign- or zero-extends it.
//   aluop_i  load op code
//   lane_i   address bits 1:0
//   rdata_i  raw bus read word
//   data_o   extended register value
module load_extend
  import mem_access_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop_i,
  input  logic [1:0]          lane_i,
  input  logic [RegBus-1:0]   rdata_i,
  output logic [RegBus-1:0]   data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = rdata_i[7:0];
    case (lane_i)
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    half_s = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (aluop_i)
      EXE_LB_OP:  data_o = {{24{byte_s[7]}}, byte_s};
      EXE_LBU_OP: data_o = {24'd0, byte_s};
      EXE_LH_OP:  data_o = {{16{half_s[15]}}, half_s};
      EXE_LHU_OP: data_o = {16'd0, half_s};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through, runs loads/stores over
// a single-outstanding data bus and stalls the pipeline until the access
// completes.
//   clk, rst                        clock, synchronous active-high reset
//   stall                           pipeline stall vector (bit 4 = WB held)
//   mem_wd/mem_wreg/mem_wdata       EX/MEM destination, enable, ALU result
//   mem_aluop/mem_mem_addr/mem_reg2 op, effective address, store source
//   wd_o/wreg_o/wdata_o             result towards MEM/WB
//   stallreq_o                      freeze IF..MEM while the bus is busy
//   misalign_o                      misaligned access dropped
//   bus                             data-bus master port
//
// state   | meaning
// IDLE    | pass-through; memory op issues its request this cycle
// WAIT    | request outstanding, waiting for ack
// DONE    | load result presented until WB accepts it
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [AluOpBus-1:0]   mem_aluop,
  input  logic [RegBus-1:0]     mem_mem_addr,
  input  logic [RegBus-1:0]     mem_reg2,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stallreq_o,
  output logic                  misalign_o,
  mem_access_if.master          bus
);

  state_e            state_q;
  logic [RegBus-1:0] load_q;

  logic              load_op, store_op, mem_op, bad_align;
  logic              issue, bus_active, ack_hit;
  logic [RegBus-1:0] ext_data;
  logic              unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  assign load_op   = is_load_op(mem_aluop);
  assign store_op  = is_store_op(mem_aluop);
  assign mem_op    = load_op | store_op;
  assign bad_align = is_misaligned(mem_aluop, mem_mem_addr[1:0]);

  // Outputs are gated by rst so the stage is silent for the whole reset
  // cycle, not just after the reset edge.
  assign issue      = !rst && (state_q == ST_IDLE) && mem_op && !bad_align;
  assign bus_active = issue || (!rst && (state_q == ST_WAIT));
  assign ack_hit    = bus_active && bus.bus_ack_i;

  load_extend u_load_extend (
    .aluop_i (mem_aluop),
    .lane_i  (mem_mem_addr[1:0]),
    .rdata_i (bus.bus_rdata_i),
    .data_o  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q <= ack_hit ? ST_DONE : ST_WAIT;
            if (ack_hit) load_q <= load_op ? ext_data : '0;
          end
        end
        ST_WAIT: begin
          if (ack_hit) begin
            state_q <= ST_DONE;
            load_q  <= load_op ? ext_data : '0;
          end
        end
        ST_DONE: begin
          if (stall[4] != Stop) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    if (!rst) begin
      wd_o = mem_wd;
      case (state_q)
        ST_IDLE: begin
          if (!mem_op) begin
            wreg_o  = mem_wreg;
            wdata_o = mem_wdata;
          end else if (bad_align) begin
            misalign_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        ST_WAIT: stallreq_o = 1'b1;
        ST_DONE: begin
          wreg_o  = load_op & mem_wreg;
          wdata_o = load_q;
        end
        default: ;
      endcase
    end
  end

  // Bus fields come straight from the EX/MEM inputs, which the stall keeps
  // frozen while the request is outstanding.
  always_comb begin
    bus.bus_req_o   = bus_active;
    bus.bus_we_o    = 1'b0;
    bus.bus_sel_o   = '0;
    bus.bus_addr_o  = '0;
    bus.bus_wdata_o = '0;
    if (bus_active) begin
      bus.bus_we_o   = store_op;
      bus.bus_sel_o  = bus_lanes(mem_aluop, mem_mem_addr[1:0]);
      bus.bus_addr_o = {mem_mem_addr[31:2], 2'b00};
      case (mem_aluop)
        EXE_SB_OP: bus.bus_wdata_o = {4{mem_reg2[7:0]}};
        EXE_SH_OP: bus.bus_wdata_o = {2{mem_reg2[15:0]}};
        EXE_SW_OP: bus.bus_wdata_o = mem_reg2;
        default:   bus.bus_wdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, misalign_o;
  logic [31:0] wdata_o;

  int checks = 0;
  int errors = 0;

  mem_access_if bus_if ();

  mem_access dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic bit m_store(input logic [7:0] op);
    return (op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP);
  endfunction

  function automatic bit m_load(input logic [7:0] op);
    return (op_size(op) != 0) && !m_store(op);
  endfunction

  function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
    int sz = op_size(op);
    return (sz != 0) && ((addr % sz) != 0);
  endfunction

  function automatic logic [31:0] m_extend(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int sz = op_size(op);
    longint unsigned mask, v;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v = ({32'd0, rdata} >> (8 * (addr % 4))) & mask;
    if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[8*sz-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
    int s;
    if (!m_store(op)) return 4'hF;
    s = ((1 << op_size(op)) - 1) << (addr % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] reg2);
    case (op_size(op))
      1: return {24'd0, reg2[7:0]} * 32'h0101_0101;
      2: return {16'd0, reg2[15:0]} * 32'h0001_0001;
      default: return reg2;
    endcase
  endfunction

  bit          m_busy = 1'b0;  // request outstanding
  bit          m_done = 1'b0;  // result being presented
  logic [31:0] m_res  = '0;

  always @(posedge clk) begin
    bit req;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = '0;
    end else if (m_done) begin
      if (!stall[4]) m_done = 1'b0;
    end else begin
      req = m_busy || (op_size(mem_aluop) != 0 && !m_misaligned(mem_aluop, mem_mem_addr));
      if (req && bus_if.bus_ack_i) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_load(mem_aluop) ? m_extend(mem_aluop, mem_mem_addr, bus_if.bus_rdata_i) : 32'd0;
      end else if (req) begin
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit idle, memop, mis, req;
    logic [4:0]  e_wd;
    logic        e_wreg, e_mis, e_we;
    logic [31:0] e_wdata, e_addr, e_bwd;
    logic [3:0]  e_sel;
    e_wd = '0; e_wreg = 0; e_mis = 0; e_we = 0; e_wdata = '0; e_addr = '0; e_bwd = '0;
    e_sel = '0; req = 0;
    if (!rst) begin
      idle  = !m_busy && !m_done;
      memop = op_size(mem_aluop) != 0;
      mis   = m_misaligned(mem_aluop, mem_mem_addr);
      req   = m_busy || (idle && memop && !mis);
      e_mis = idle && memop && mis;
      e_wd  = mem_wd;
      if (idle && !memop) begin
        e_wreg = mem_wreg; e_wdata = mem_wdata;
      end else if (m_done) begin
        e_wreg = m_load(mem_aluop) && mem_wreg; e_wdata = m_res;
      end
      if (req) begin
        e_we   = m_store(mem_aluop);
        e_addr = mem_mem_addr & ~32'd3;
        e_sel  = m_sel(mem_aluop, mem_mem_addr);
        e_bwd  = m_store(mem_aluop) ? m_wdata(mem_aluop, mem_reg2) : 32'd0;
      end
    end
    chk("cmp_wd",       {27'd0, wd_o}, {27'd0, e_wd});
    chk("cmp_wreg",     {31'd0, wreg_o}, {31'd0, e_wreg});
    chk("cmp_wdata",    wdata_o, e_wdata);
    chk("cmp_stallreq", {31'd0, stallreq_o}, {31'd0, req});
    chk("cmp_misalign", {31'd0, misalign_o}, {31'd0, e_mis});
    chk("cmp_bus_req",  {31'd0, bus_if.bus_req_o}, {31'd0, req});
    chk("cmp_bus_we",   {31'd0, bus_if.bus_we_o}, {31'd0, e_we});
    chk("cmp_bus_sel",  {28'd0, bus_if.bus_sel_o}, {28'd0, e_sel});
    chk("cmp_bus_addr", bus_if.bus_addr_o, e_addr);
    chk("cmp_bus_wdata", bus_if.bus_wdata_o, e_bwd);
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] reg2);
    mem_aluop = op; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    mem_mem_addr = addr; mem_reg2 = reg2;
  endtask

  task automatic do_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                         input int waits, input logic [31:0] exp);
    int n_stall = 0;
    @(posedge clk); #1;
    set_in(op, 5'd9, 1'b1, 32'h0, addr, 32'h0);
    bus_if.bus_rdata_i = rdata;
    for (int i = 0; i <= waits; i++) begin
      bus_if.bus_ack_i = (i == waits);
      @(negedge clk);
      if (i == 0) chk("ld_addr", bus_if.bus_addr_o, addr & ~32'd3);
      if (stallreq_o) n_stall++;
      @(posedge clk); #1;
    end
    bus_if.bus_ack_i = 1'b0;
    @(negedge clk);
    chk("ld_result", wdata_o, exp);
    chk("ld_wreg", {31'd0, wreg_o}, 32'd1);
    chk("ld_stall_cycles", n_stall, waits + 1);
  endtask

  task automatic do_store(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input int waits, input logic [3:0] esel, input logic [31:0] edata);
    @(posedge clk); #1;
    set_in(op, 5'd7, 1'b1, 32'h0, addr, reg2);
    for (int i = 0; i <= waits; i++) begin
      bus_if.bus_ack_i = (i == waits);
      @(negedge clk);
      if (i == 0) begin
        chk("st_sel", {28'd0, bus_if.bus_sel_o}, {28'd0, esel});
        chk("st_wdata", bus_if.bus_wdata_o, edata);
        chk("st_we", {31'd0, bus_if.bus_we_o}, 32'd1);
        chk("st_wreg_req", {31'd0, wreg_o}, 32'd0);
      end
      @(posedge clk); #1;
    end
    bus_if.bus_ack_i = 1'b0;
    @(negedge clk);
    chk("st_done_req", {31'd0, bus_if.bus_req_o}, 32'd0);
    chk("st_done_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("st_done_wreg", {31'd0, wreg_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = '0;
    set_in(EXE_NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus_if.bus_ack_i = 1'b0; bus_if.bus_rdata_i = '0;
    @(posedge clk); #1;
    set_in(EXE_LW_OP, 5'd4, 1'b1, 32'h77, 32'h40, 32'h0);
    @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_if.bus_req_o}, 32'd0);
    chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);

    // ALU pass-through
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(EXE_ADD_OP, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
    @(negedge clk);
    chk("add_wd", {27'd0, wd_o}, 32'd5);
    chk("add_wreg", {31'd0, wreg_o}, 32'd1);
    chk("add_wdata", wdata_o, 32'h1234);
    chk("add_stallreq", {31'd0, stallreq_o}, 32'd0);

    do_load(EXE_LB_OP,  32'h103, 32'h80FF_FF7F, 2, 32'hFFFF_FF80);
    do_load(EXE_LH_OP,  32'h006, 32'h8001_1234, 0, 32'hFFFF_8001);
    do_load(EXE_LBU_OP, 32'h001, 32'h0000_9000, 1, 32'h0000_0090);
    do_load(EXE_LW_OP,  32'h008, 32'hCAFE_F00D, 3, 32'hCAFE_F00D);
    do_load(EXE_LB_OP,  32'h000, 32'h1234_567F, 0, 32'h0000_007F);

    do_store(EXE_SH_OP, 32'h202, 32'hDEAD_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
    do_store(EXE_SB_OP, 32'h005, 32'h1234_5678, 1, 4'b0010, 32'h7878_7878);
    do_store(EXE_SW_OP, 32'h010, 32'hA5A5_0F0F, 0, 4'b1111, 32'hA5A5_0F0F);

    // misaligned accesses are dropped
    @(posedge clk); #1;
    set_in(EXE_LW_OP, 5'd3, 1'b1, 32'h0, 32'h101, 32'h0);
    @(negedge clk);
    chk("mis_lw_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_lw_req", {31'd0, bus_if.bus_req_o}, 32'd0);
    chk("mis_lw_wreg", {31'd0, wreg_o}, 32'd0);
    chk("mis_lw_stallreq", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    set_in(EXE_NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
    @(posedge clk); #1;
    set_in(EXE_SH_OP, 5'd3, 1'b1, 32'h0, 32'h011, 32'h1111);
    @(negedge clk);
    chk("mis_sh_pulse", {31'd0, misalign_o}, 32'd1);

    // LHU completes while write-back is held for two cycles
    @(posedge clk); #1;
    set_in(EXE_LHU_OP, 5'd6, 1'b1, 32'h0, 32'h002, 32'h0);
    bus_if.bus_rdata_i = 32'h8001_0000; bus_if.bus_ack_i = 1'b1; stall = 6'b011111;
    @(negedge clk);
    chk("lhu_stallreq", {31'd0, stallreq_o}, 32'd1);
    @(posedge clk); #1;
    bus_if.bus_ack_i = 1'b0;
    @(negedge clk);
    chk("lhu_done1", wdata_o, 32'h0000_8001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lhu_done2", wdata_o, 32'h0000_8001);
    @(posedge clk); #1;
    stall = '0;
    @(negedge clk);
    chk("lhu_done3", wdata_o, 32'h0000_8001);
    chk("lhu_done3_stallreq", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    set_in(EXE_ADD_OP, 5'd2, 1'b1, 32'h0000_0042, 32'h0, 32'h0);
    @(negedge clk);
    chk("lhu_back_idle", wdata_o, 32'h0000_0042);

    // reset while a request is outstanding; the late ack must be ignored
    @(posedge clk); #1;
    set_in(EXE_LW_OP, 5'd9, 1'b1, 32'h0, 32'h300, 32'h0);
    @(negedge clk);
    chk("rw_req", {31'd0, bus_if.bus_req_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rw_rst_req", {31'd0, bus_if.bus_req_o}, 32'd0);
    chk("rw_rst_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("rw_rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rw_rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rw_rst_sel", {28'd0, bus_if.bus_sel_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(EXE_NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rw_late_ack_req", {31'd0, bus_if.bus_req_o}, 32'd0);
    chk("rw_late_ack_wdata", wdata_o, 32'd0);
    @(posedge clk); #1;
    bus_if.bus_ack_i = 1'b0;
    set_in(EXE_ADD_OP, 5'd3, 1'b1, 32'h55, 32'h0, 32'h0);
    @(negedge clk);
    chk("rw_idle_after", wdata_o, 32'h55);
    chk("rw_idle_stallreq", {31'd0, stallreq_o}, 32'd0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
